// File: rtl/lut_ff_mux_stim_checker.sv
// lut_ff_mux_stim_checker
// On-chip stimulus sequencer and Q-compare checker for the lut_ff_mux benchmark.
// Drives a golden and a netlist instance with the same vector stream
// (one reset vector, four directed vectors, then LFSR vectors), compares their
// Q outputs on each vector's closing edge and reports saturating counts and a
// pass flag once the run finishes.
module lut_ff_mux_stim_checker #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned NUM_RANDOM = 100,
  parameter int unsigned SETTLE_CYC = 1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [DATA_W-1:0] stim_in,
  output logic              stim_sel,
  output logic              dut_rst,
  input  logic              q_golden,
  input  logic              q_netlist,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [CNT_W-1:0]  vector_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RSTV,
    S_DIR,
    S_RAND,
    S_DRAIN,
    S_DONE
  } state_t;

  // A zero seed would lock the LFSR, so it is replaced by the default.
  localparam logic [15:0] SEED       = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [31:0] PH_LAST    = 32'(SETTLE_CYC + 1);
  localparam logic [31:0] DIR_LAST   = 32'd3;
  localparam logic [31:0] RAND_LAST  = (NUM_RANDOM == 0) ? 32'd0 : 32'(NUM_RANDOM - 1);
  localparam logic [31:0] DRAIN_LAST = 32'd4;

  state_t state_q, state_d;
  // Cycle position inside the current vector: 0=APPLY, 1..SETTLE_CYC=SETTLE, last=CHECK.
  logic [31:0] ph_q;
  // Vector index inside DIR/RAND, or cycle index inside DRAIN.
  logic [31:0] cnt_q;
  logic [15:0] lfsr_q, lfsr_d, lfsr_nxt;

  logic [DATA_W-1:0] stim_d;
  logic              sel_d, drst_d, busy_d, done_d, pass_d;
  logic [CNT_W-1:0]  mcnt_d, vcnt_d;

  logic in_vec, check_now, accept_start, state_chg;

  // Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (shift right, mask 0xB400).
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Directed vectors: {4,0}, {4,1}, {1,0}, {1,1}.
  function automatic logic [DATA_W:0] dir_vec(input logic [1:0] i);
    logic [DATA_W-1:0] s;
    s = i[1] ? DATA_W'(1) : DATA_W'(4);
    return {s, i[0]};
  endfunction

  assign in_vec       = (state_q == S_RSTV) || (state_q == S_DIR) || (state_q == S_RAND);
  assign check_now    = in_vec && (ph_q == PH_LAST);
  assign accept_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign state_chg    = (state_d != state_q);
  assign lfsr_nxt     = lfsr_step(lfsr_q);

  // State register with per-vector phase and index counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (in_vec && !check_now) ph_q <= ph_q + 32'd1;
      else                      ph_q <= '0;
      if (state_chg)                           cnt_q <= '0;
      else if (check_now || state_q == S_DRAIN) cnt_q <= cnt_q + 32'd1;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RSTV;
      S_RSTV:  if (check_now) state_d = S_DIR;
      S_DIR:   if (check_now && cnt_q == DIR_LAST)
                 state_d = (NUM_RANDOM == 0) ? S_DRAIN : S_RAND;
      S_RAND:  if (check_now && cnt_q == RAND_LAST) state_d = S_DRAIN;
      S_DRAIN: if (cnt_q == DRAIN_LAST) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, counters and LFSR.
  // The vector loaded on a CHECK edge is the APPLY of the following vector,
  // so stimulus for vector N+1 is chosen from the state being entered.
  always_comb begin
    stim_d = stim_in;
    sel_d  = stim_sel;
    drst_d = dut_rst;
    lfsr_d = lfsr_q;
    busy_d = busy;
    done_d = done;
    pass_d = pass;
    mcnt_d = mismatch_cnt;
    vcnt_d = vector_cnt;
    if (accept_start) begin
      stim_d = '0;
      sel_d  = 1'b0;
      drst_d = 1'b1;
      lfsr_d = SEED;
      busy_d = 1'b1;
      done_d = 1'b0;
      pass_d = 1'b0;
      mcnt_d = '0;
      vcnt_d = '0;
    end else begin
      if (check_now) begin
        if (vector_cnt != '1) vcnt_d = vector_cnt + CNT_W'(1);
        if ((q_golden != q_netlist) && (mismatch_cnt != '1))
          mcnt_d = mismatch_cnt + CNT_W'(1);
      end
      if (state_chg) begin
        unique case (state_d)
          S_DIR: begin
            drst_d          = 1'b0;
            {stim_d, sel_d} = dir_vec(2'd0);
          end
          S_RAND: begin
            drst_d = 1'b0;
            lfsr_d = lfsr_nxt;
            stim_d = lfsr_nxt[DATA_W-1:0];
            sel_d  = lfsr_nxt[DATA_W];
          end
          S_DRAIN: drst_d = 1'b0;
          S_DONE: begin
            drst_d = 1'b1;
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (mismatch_cnt == '0);
          end
          default: ;
        endcase
      end else if (check_now && state_q == S_DIR) begin
        {stim_d, sel_d} = dir_vec(2'(cnt_q) + 2'd1);
      end else if (check_now && state_q == S_RAND) begin
        lfsr_d = lfsr_nxt;
        stim_d = lfsr_nxt[DATA_W-1:0];
        sel_d  = lfsr_nxt[DATA_W];
      end
    end
  end

  // Output, counter and LFSR registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stim_in      <= '0;
      stim_sel     <= 1'b0;
      dut_rst      <= 1'b1;
      lfsr_q       <= SEED;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      vector_cnt   <= '0;
    end else begin
      stim_in      <= stim_d;
      stim_sel     <= sel_d;
      dut_rst      <= drst_d;
      lfsr_q       <= lfsr_d;
      busy         <= busy_d;
      done         <= done_d;
      pass         <= pass_d;
      mismatch_cnt <= mcnt_d;
      vector_cnt   <= vcnt_d;
    end
  end

endmodule
